de10lite_input_cond: RTL and testbench

Input-conditioning stage that sits between the DE10-Lite board pins and the MMIO control-register block, feeding its `Button_0`, `Button_1`, `Switch` and `Arduino_dg_io` inputs. It synchronizes every asynchronous pin into `QClk`, debounces each bit independently, and presents clean levels plus single-cycle rising-edge pulses. Software then reads stable values through the read-only CRs and never sees metastable or bouncing data.

---
 rtl/lotr_pkg.sv | 15 +
 rtl/de10lite_debounce_bit.sv | 62 ++++++
 rtl/de10lite_input_cond.sv | 80 ++++++++
 tb/tb_de10lite_input_cond.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lotr_pkg.sv
// Shared definitions for the DE10-Lite input-conditioning path.
// Holds the raw pin bundle layout that fixes the bit order of the conditioned outputs.
package lotr_pkg;

    localparam int DE10_DEBOUNCE_CYCLES_DEF = 500000;
    localparam int DE10_NUM_IN_BITS         = 28;

    typedef struct packed {
        logic [15:0] ArduinoRaw;
        logic [9:0]  SwitchRaw;
        logic        Key_1_n;
        logic        Key_0_n;
    } t_fpga_in_raw;

endpackage

// File: rtl/de10lite_debounce_bit.sv
// Purpose: synchronize, debounce and edge-detect one asynchronous input bit.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES to the stable level; rise pulse coincident with it.
// Backpressure: none, free-running level path.
module de10lite_debounce_bit
    import lotr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DE10_DEBOUNCE_CYCLES_DEF
) (
    input  logic QClk,
    input  logic RstQnnnH,
    input  logic din,
    output logic stb,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          stb_q,   stb_d;
    logic          pulse_q, pulse_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        stb_d   = stb_q;
        cnt_d   = cnt_q;
        if (sync2_q == stb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // Registered form of stb & ~stb_delayed: uses next-state values so the
        // pulse lands on the same cycle stb first reads 1.
        pulse_d = stb_d & ~stb_q;
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            pulse_q <= pulse_d;
        end
    end

    assign stb        = stb_q;
    assign rise_pulse = pulse_q;

endmodule

// File: rtl/de10lite_input_cond.sv
// Purpose: condition all DE10-Lite keys/switches/Arduino pins; optional press counters via DE10_BTN_EVENT_CNT_EN.
// Latency: 2 + DEBOUNCE_CYCLES cycles pin-to-level; counters lag RisePulse by 1 cycle.
// Backpressure: none, outputs are continuously valid levels and pulses.
module de10lite_input_cond
    import lotr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DE10_DEBOUNCE_CYCLES_DEF
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic        Key_0_n,
    input  logic        Key_1_n,
    input  logic [9:0]  SwitchRaw,
    input  logic [15:0] ArduinoRaw,
    output logic        Button_0,
    output logic        Button_1,
    output logic [9:0]  Switch,
    output logic [15:0] Arduino_dg_io,
    output logic [27:0] RisePulse
`ifdef DE10_BTN_EVENT_CNT_EN
    ,
    output logic [15:0] BtnCnt0,
    output logic [15:0] BtnCnt1
`endif
);

    t_fpga_in_raw                pin_raw;
    logic [DE10_NUM_IN_BITS-1:0] in_act;
    logic [DE10_NUM_IN_BITS-1:0] stb_vec;
    logic [DE10_NUM_IN_BITS-1:0] rise_vec;

    assign pin_raw = '{ArduinoRaw: ArduinoRaw, SwitchRaw: SwitchRaw,
                       Key_1_n: Key_1_n, Key_0_n: Key_0_n};

    // Keys are flipped before the synchronizers so every bit is active-high downstream.
    assign in_act = {pin_raw.ArduinoRaw, pin_raw.SwitchRaw, ~pin_raw.Key_1_n, ~pin_raw.Key_0_n};

    for (genvar i = 0; i < DE10_NUM_IN_BITS; i++) begin : g_bit
        de10lite_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .QClk      (QClk),
            .RstQnnnH  (RstQnnnH),
            .din       (in_act[i]),
            .stb       (stb_vec[i]),
            .rise_pulse(rise_vec[i])
        );
    end

    assign Button_0      = stb_vec[0];
    assign Button_1      = stb_vec[1];
    assign Switch        = stb_vec[11:2];
    assign Arduino_dg_io = stb_vec[27:12];
    assign RisePulse     = rise_vec;

`ifdef DE10_BTN_EVENT_CNT_EN
    logic [15:0] btn_cnt0_q, btn_cnt0_d;
    logic [15:0] btn_cnt1_q, btn_cnt1_d;

    // Free-running wrap at 16 bits; software handles rollover.
    always_comb begin
        btn_cnt0_d = btn_cnt0_q + {15'd0, rise_vec[0]};
        btn_cnt1_d = btn_cnt1_q + {15'd0, rise_vec[1]};
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            btn_cnt0_q <= '0;
            btn_cnt1_q <= '0;
        end else begin
            btn_cnt0_q <= btn_cnt0_d;
            btn_cnt1_q <= btn_cnt1_d;
        end
    end

    assign BtnCnt0 = btn_cnt0_q;
    assign BtnCnt1 = btn_cnt1_q;
`endif

endmodule

// File: tb/tb_de10lite_input_cond.sv
// Bench for de10lite_input_cond with DEBOUNCE_CYCLES=4; counter checks active when DE10_BTN_EVENT_CNT_EN is defined.
module tb_de10lite_input_cond;

    logic        clk = 1'b0;
    logic        rst;
    logic        key0_n, key1_n;
    logic [9:0]  sw_raw;
    logic [15:0] ard_raw;
    logic        btn0, btn1;
    logic [9:0]  sw;
    logic [15:0] ard;
    logic [27:0] rise;
`ifdef DE10_BTN_EVENT_CNT_EN
    logic [15:0] cnt0, cnt1;
`endif

    de10lite_input_cond #(.DEBOUNCE_CYCLES(4)) dut (
        .QClk         (clk),
        .RstQnnnH     (rst),
        .Key_0_n      (key0_n),
        .Key_1_n      (key1_n),
        .SwitchRaw    (sw_raw),
        .ArduinoRaw   (ard_raw),
        .Button_0     (btn0),
        .Button_1     (btn1),
        .Switch       (sw),
        .Arduino_dg_io(ard),
        .RisePulse    (rise)
`ifdef DE10_BTN_EVENT_CNT_EN
        ,
        .BtnCnt0      (cnt0),
        .BtnCnt1      (cnt1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [27:0] lvl;
        logic [27:0] pls;
    } exp_t;

    exp_t        exp_q[$];
    logic [27:0] exp_lvl  = '0;
    logic [27:0] prev_lvl = '0;
    int          total = 0;
    int          bad   = 0;

    // Scoreboard monitor: any level change or pulse is an output event.
    always @(negedge clk) begin
        logic [27:0] lvl;
        exp_t        e;
        lvl = {ard, sw, btn1, btn0};
        if (lvl != prev_lvl || rise != '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d lvl=%h pulse=%h (no event required)", cyc, lvl, rise);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.lvl != lvl || e.pls != rise) begin
                    bad++;
                    $display("FAIL event cyc=%0d lvl=%h pulse=%h, required cyc=%0d lvl=%h pulse=%h",
                             cyc, lvl, rise, e.cyc, e.lvl, e.pls);
                end
            end
        end
        prev_lvl = lvl;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h (cyc=%0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int c, input logic [27:0] new_lvl, input logic [27:0] pls);
        exp_t e;
        e.cyc = c;
        e.lvl = new_lvl;
        e.pls = pls;
        exp_q.push_back(e);
        exp_lvl = new_lvl;
    endtask

    task automatic step(output int k);
        @(posedge clk);
        #1;
        k = cyc;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2;
        rst = 1'b1; key0_n = 1'b1; key1_n = 1'b1; sw_raw = '0; ard_raw = '0;

        // Reset state
        repeat (5) @(negedge clk);
        check("rst_btn0", {31'd0, btn0}, 32'd0);
        check("rst_btn1", {31'd0, btn1}, 32'd0);
        check("rst_switch", {22'd0, sw}, 32'd0);
        check("rst_arduino", {16'd0, ard}, 32'd0);
        check("rst_pulse", {4'd0, rise}, 32'd0);
`ifdef DE10_BTN_EVENT_CNT_EN
        check("rst_cnt0", {16'd0, cnt0}, 32'd0);
        check("rst_cnt1", {16'd0, cnt1}, 32'd0);
`endif
        step(k);
        rst = 1'b0;
        wait_cyc(k + 20);
        check("post_rst_levels", {4'd0, ard, sw, btn1, btn0}, 32'd0);

        // Clean press on KEY0
        step(k);
        key0_n = 1'b0;
        expect_ev(k + 6, exp_lvl | 28'h1, 28'h1);
        wait_cyc(k + 5);
        check("press_btn0_early", {31'd0, btn0}, 32'd0);
        wait_cyc(k + 6);
        check("press_btn0", {31'd0, btn0}, 32'd1);
`ifdef DE10_BTN_EVENT_CNT_EN
        check("press_cnt0_k6", {16'd0, cnt0}, 32'd0);
        wait_cyc(k + 7);
        check("press_cnt0_k7", {16'd0, cnt0}, 32'd1);
`endif
        wait_cyc(k + 10);
        step(k);
        key0_n = 1'b1;
        expect_ev(k + 6, exp_lvl & ~28'h1, 28'h0);
        wait_cyc(k + 10);

        // Bouncing switch 3: 3 high, 1 low, 3 high, low
        step(k); sw_raw[3] = 1'b1;
        step(k); step(k);
        step(k); sw_raw[3] = 1'b0;
        step(k); sw_raw[3] = 1'b1;
        step(k); step(k);
        step(k); sw_raw[3] = 1'b0;
        wait_cyc(k + 15);
        check("bounce_switch3", {31'd0, sw[3]}, 32'd0);

        // Press then release KEY1
        step(k);
        key1_n = 1'b0;
        expect_ev(k + 6, exp_lvl | 28'h2, 28'h2);
        wait_cyc(k + 10);
        step(k2);
        key1_n = 1'b1;
        expect_ev(k2 + 6, exp_lvl & ~28'h2, 28'h0);
        wait_cyc(k2 + 5);
        check("release_btn1_held", {31'd0, btn1}, 32'd1);
        wait_cyc(k2 + 6);
        check("release_btn1", {31'd0, btn1}, 32'd0);
`ifdef DE10_BTN_EVENT_CNT_EN
        check("release_cnt1", {16'd0, cnt1}, 32'd1);
`endif
        wait_cyc(k2 + 10);

        // Parallel Arduino pattern
        step(k);
        ard_raw = 16'hA5A5;
        expect_ev(k + 6, exp_lvl | {16'hA5A5, 12'h000}, {16'hA5A5, 12'h000});
        wait_cyc(k + 6);
        check("par_arduino", {16'd0, ard}, 32'h0000A5A5);
        check("par_pulse", {16'd0, rise[27:12]}, 32'h0000A5A5);
        wait_cyc(k + 7);
        check("par_pulse_gone", {4'd0, rise}, 32'd0);
        wait_cyc(k + 10);

`ifdef DE10_BTN_EVENT_CNT_EN
        // Counter wrap from 16'hFFFF
        @(negedge clk);
        force dut.btn_cnt0_q = 16'hFFFF;
        @(negedge clk);
        release dut.btn_cnt0_q;
        step(k);
        key0_n = 1'b0;
        expect_ev(k + 6, exp_lvl | 28'h1, 28'h1);
        wait_cyc(k + 6);
        check("wrap_cnt0_pre", {16'd0, cnt0}, 32'h0000FFFF);
        wait_cyc(k + 7);
        check("wrap_cnt0", {16'd0, cnt0}, 32'd0);
        wait_cyc(k + 10);
        step(k);
        key0_n = 1'b1;
        expect_ev(k + 6, exp_lvl & ~28'h1, 28'h0);
        wait_cyc(k + 10);
`endif

        // Return Arduino to idle
        step(k);
        ard_raw = 16'h0000;
        expect_ev(k + 6, exp_lvl & ~{16'hFFFF, 12'h000}, 28'h0);
        wait_cyc(k + 10);

        // Reset mid-debounce on switch 0
        step(k);
        sw_raw[0] = 1'b1;
        step(k2); step(k2); step(k2);
        rst = 1'b1;
        step(k2);
        rst = 1'b0;
        expect_ev(k + 10, exp_lvl | 28'h4, 28'h4);
        wait_cyc(k + 9);
        check("mid_rst_switch0_early", {31'd0, sw[0]}, 32'd0);
        wait_cyc(k + 10);
        check("mid_rst_switch0", {31'd0, sw[0]}, 32'd1);
        wait_cyc(k + 15);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
